// File: rtl/mux_cl_seq_pkg.sv
// rtl/mux_cl_seq_pkg.sv - shared types and helpers for the registered N:1 channel mux
package mux_cl_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FULL = 1'b1
  } state_e;

  // Ceiling log2 usable in parameter expressions; NCH need not be a power of two.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_cl_seq_if.sv
// rtl/mux_cl_seq_if.sv - request, channel data and output handshake bundle for mux_cl_seq
interface mux_cl_seq_if
  import mux_cl_pkg::*;
#(
  parameter int NCH = 8,
  parameter int W   = 1
) ();
  localparam int SELW = clog2(NCH);

  logic [NCH*W-1:0] din;
  logic [NCH-1:0]   ch_en;
  logic             mode;
  logic [SELW-1:0]  sel_in;
  logic             sel_vld;
  logic             sel_rdy;
  logic [W-1:0]     dout;
  logic [SELW-1:0]  dout_ch;
  logic             dout_err;
  logic             dout_vld;
  logic             dout_rdy;

  modport master (
    output din, ch_en, mode, sel_in, sel_vld, dout_rdy,
    input  sel_rdy, dout, dout_ch, dout_err, dout_vld
  );

  modport slave (
    input  din, ch_en, mode, sel_in, sel_vld, dout_rdy,
    output sel_rdy, dout, dout_ch, dout_err, dout_vld
  );
endinterface

// File: rtl/mux_cl_seq_rr_next_en.sv
// rtl/mux_cl_seq_rr_next_en.sv - round-robin search for the next enabled channel after ptr
module rr_next_en
  import mux_cl_pkg::*;
#(
  parameter int NCH  = 8,
  parameter int SELW = clog2(NCH)
) (
  input  logic [SELW-1:0] i_ptr,
  input  logic [NCH-1:0]  i_ch_en,
  output logic [SELW-1:0] o_nxt,
  output logic            o_any
);

  int w_sum;

  assign o_any = |i_ch_en;

  // Walk candidates from farthest (ptr itself) to nearest so the closest hit after ptr wins.
  always_comb begin
    o_nxt = i_ptr;
    w_sum = 0;
    for (int k = NCH; k >= 1; k--) begin
      w_sum = int'(i_ptr) + k;
      if (w_sum >= NCH) w_sum = w_sum - NCH;
      if (i_ch_en[w_sum[SELW-1:0]]) o_nxt = w_sum[SELW-1:0];
    end
  end

endmodule

// File: rtl/mux_cl_seq.sv
// rtl/mux_cl_seq.sv - registered N:1 channel mux with DIRECT select and round-robin SCAN modes
module mux_cl_seq
  import mux_cl_pkg::*;
#(
  parameter int NCH = 8,
  parameter int W   = 1
) (
  input logic         clk,
  input logic         rst_n,
  mux_cl_seq_if.slave bus
);

  localparam int SELW = clog2(NCH);
  localparam logic [0:0] ST_IDLE = S_IDLE;
  localparam logic [0:0] ST_FULL = S_FULL;

  logic [0:0]      r_state;
  logic [W-1:0]    r_dout;
  logic [SELW-1:0] r_ch;
  logic            r_err;
  logic [SELW-1:0] r_ptr;

  logic            w_scan;
  logic            w_load_ok;
  logic            w_load;
  logic            w_any;
  logic            w_hit;
  logic [SELW-1:0] w_nxt;
  logic [SELW-1:0] w_ch;
  logic [W-1:0]    w_data;

  rr_next_en #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_rr (
    .i_ptr   (r_ptr),
    .i_ch_en (bus.ch_en),
    .o_nxt   (w_nxt),
    .o_any   (w_any)
  );

  assign w_scan    = (bus.mode == MODE_SCAN);
  assign w_load_ok = (r_state == ST_IDLE) | bus.dout_rdy;
  assign w_ch      = w_scan ? w_nxt : bus.sel_in;

  // Requests are not acknowledged while reset is asserted, since reset discards any load.
  assign w_load    = rst_n & w_load_ok & (w_scan ? w_any : bus.sel_vld);
  assign bus.sel_rdy = rst_n & w_load_ok & ~w_scan;

  // An index with no matching channel leaves w_hit low and the data at zero.
  always_comb begin
    w_data = '0;
    w_hit  = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (w_ch == SELW'(c)) begin
        w_data = bus.din[c*W +: W];
        w_hit  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_dout  <= '0;
      r_ch    <= '0;
      r_err   <= 1'b0;
      r_ptr   <= SELW'(NCH - 1);
    end else begin
      if (w_load) begin
        r_state <= ST_FULL;
        r_dout  <= w_data;
        r_ch    <= w_ch;
        r_err   <= ~w_scan & ~w_hit;
        if (w_scan) r_ptr <= w_nxt;
      end else if (bus.dout_rdy) begin
        r_state <= ST_IDLE;
      end
    end
  end

  assign bus.dout     = r_dout;
  assign bus.dout_ch  = r_ch;
  assign bus.dout_err = r_err;
  assign bus.dout_vld = (r_state == ST_FULL);

endmodule
